impulse_capture: RTL and testbench
==================================

# impulse_capture

Strobe-protocol sample sink for the moving-average datapath. It receives the 10-bit filtered samples on `data_in`/`strobe_in`, waits for the first sample above a threshold, and captures the next DEPTH strobed samples into an internal buffer. It also computes the sum, peak and response length of the captured samples. It sits on the moving-average output so impulse and step responses can be checked on-chip and read back through a simple registered read port.

## Interface
- `DATA_W`, 10: sample width; matches the moving-average output.
- `DEPTH`, 16: samples captured per trigger; must be a power of two, at least 2.
- `THRESH`, 0: trigger when the sample is strictly greater than this value (unsigned).
- `clk`  in  1  the single clock for the block; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `arm`  in  1  one-cycle pulse; clears results and enters ARMED.
- `strobe_in`  in  1  sample-valid qualifier; one strobe transfers one sample.
- `data_in`  in  DATA_W  sample; sampled only when `strobe_in`=1.
- `busy`  out  1  high in ARMED or CAPTURE.
- `done`  out  1  high in DONE.
- `rd_addr`  in  log2(DEPTH)  buffer read address.
- `rd_data`  out  DATA_W  buffer word, registered.
- `sum_out`  out  DATA_W+log2(DEPTH)  sum of the captured samples.
- `peak_out`  out  DATA_W  maximum captured sample.
- `len_out`  out  log2(DEPTH)+1  index of the last nonzero captured sample plus 1; 0 if all samples are zero.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE:
  - `arm` moves to ARMED.
  - Strobes are ignored.
- ARMED:
  - A strobe with `data_in` > THRESH stores the sample at index 0.
  - Initialises sum to the sample, peak to the sample, and len to 1 if the sample is nonzero.
  - Moves to CAPTURE with the write index at 1.
  - Strobes at or below the threshold are ignored.
- CAPTURE: each strobe writes `mem[idx]` and updates the accumulators.
  - sum += sample.
  - peak = max(peak, sample).
  - If the sample is nonzero, len = idx+1.
  - idx increments.
  - The strobe that writes idx = DEPTH-1 moves to DONE.
- DONE:
  - Results are held.
  - Strobes are ignored.
  - `arm` moves to ARMED.
- `arm` in any state goes to ARMED and zeros sum, peak, len and idx.
- `arm` and `strobe_in` in the same cycle: `arm` wins and the sample is discarded.
- The sum width never overflows: DEPTH × (2^DATA_W−1) fits in DATA_W+log2(DEPTH) bits. No saturation.
- `rst` in any state, including mid-capture:
  - Next state IDLE.
  - `busy`=0, `done`=0.
  - `sum_out`, `peak_out`, `len_out` and `rd_data` are 0.
  - Buffer contents are not cleared and are undefined until the next completed capture.

## Timing
- Outputs are registered.
- A strobe sampled at edge N updates the state and accumulators visible after edge N.
- `done` rises in the cycle after the edge that samples the DEPTH-th captured strobe.
- `busy` rises the cycle after `arm` and falls together with the rise of `done`.
- Strobes may be asserted every cycle (back-to-back) or sparsely. There is no backpressure and no minimum gap.
- `rd_data` = `mem[rd_addr]`, one cycle after `rd_addr`. It is readable in any state and valid for captured data only while `done`=1.
- `sum_out`, `peak_out` and `len_out` are valid while `done`=1. They are stable until the next `arm` or `rst`.

## Structure
- A shared package `impulse_capture_pkg` holds:
  - the state enum (IDLE/ARMED/CAPTURE/DONE);
  - the default `DATA_W`;
  - a width-function helper for the sum and len widths.
- One sub-module, `capture_buf`: a DEPTH×DATA_W single-write, single-read buffer with a synchronous read port. It has no reset on the storage array.
- The FSM, accumulators and index counter live in the top-level module.

## Test plan
- **Reset and idle.** Assert `rst` for 2 cycles, then drive 5 strobes of 1023 without `arm`.
  - `busy`=0, `done`=0, all result outputs 0 throughout.
- **Size-2 impulse response.** `arm`; 5 zero strobes; 511, 511; then 14 zero strobes, one strobe every 2 cycles.
  - Trigger on the first 511.
  - `mem[0..1]`=511, `mem[2..15]`=0.
  - `sum_out`=1022, `peak_out`=511, `len_out`=2.
  - `done` is high 1 cycle after the 16th captured strobe.
- **Size-8 impulse response.** `arm`; 8 strobes of 127, then 8 zero strobes.
  - `sum_out`=1016, `peak_out`=127, `len_out`=8.
  - Readback via `rd_addr` 0..15 returns 127×8, then 0×8, each 1 cycle after its address.
- **Full-scale back-to-back.** Set THRESH=0; `arm`; `strobe_in` high for 16 consecutive cycles with `data_in`=1023.
  - `sum_out`=16368, `peak_out`=1023, `len_out`=16.
  - `done` rises on the cycle after the 16th strobe.
- **Collision and rearm.**
  - `arm` with a strobe of 900 in the same cycle: the sample is not captured and the block stays in ARMED.
  - The next strobe of 300 triggers capture.
  - `arm` during DONE clears the results to 0 and returns the block to ARMED with `busy`=1.
- **Reset mid-capture.** Assert `rst` after 7 captured samples.
  - Next cycle: IDLE, all outputs 0.
  - A subsequent `arm` plus a fresh impulse 511, 511 yields `sum_out`=1022 and `len_out`=2.

Source files
------------

// File: rtl/impulse_capture_pkg.sv
// impulse_capture_pkg: shared state encoding, default width and result-width helpers
package impulse_capture_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam int DEF_DATA_W = 10;
  function automatic int sum_w(input int dw, input int depth);
    return dw + $clog2(depth);
  endfunction
  function automatic int len_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/capture_buf.sv
// capture_buf: DEPTH x DATA_W buffer with one write port and a registered read port
module capture_buf #(
  parameter int DATA_W = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk)
    rd_data <= rst ? '0 : mem[rd_addr];
endmodule

// File: rtl/impulse_capture.sv
// impulse_capture: threshold-triggered capture of DEPTH strobed samples with sum, peak and length
module impulse_capture
  import impulse_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = 16,
  parameter int THRESH = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               arm,
  input  logic                               strobe_in,
  input  logic [DATA_W-1:0]                  data_in,
  output logic                               busy,
  output logic                               done,
  input  logic [$clog2(DEPTH)-1:0]           rd_addr,
  output logic [DATA_W-1:0]                  rd_data,
  output logic [sum_w(DATA_W, DEPTH)-1:0]    sum_out,
  output logic [DATA_W-1:0]                  peak_out,
  output logic [len_w(DEPTH)-1:0]            len_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = sum_w(DATA_W, DEPTH);
  localparam int LW = len_w(DEPTH);
  state_t state;
  logic [AW-1:0] idx;
  logic we;
  always_comb
    we = !arm && strobe_in && (state == CAPTURE || (state == ARMED && data_in > DATA_W'(THRESH)));
  always_ff @(posedge clk)
    if (rst || arm) begin
      state    <= rst ? IDLE : ARMED;
      idx      <= '0;
      sum_out  <= '0;
      peak_out <= '0;
      len_out  <= '0;
    end else if (we) begin
      state    <= idx == AW'(DEPTH - 1) ? DONE : CAPTURE;
      idx      <= idx + AW'(1);
      sum_out  <= sum_out + SW'(data_in);
      peak_out <= data_in > peak_out ? data_in : peak_out;
      len_out  <= data_in != '0 ? LW'(idx) + LW'(1) : len_out;
    end
  assign busy = state == ARMED || state == CAPTURE;
  assign done = state == DONE;
  capture_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wr_addr(idx),
    .wr_data(data_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_impulse_capture.sv
// tb_impulse_capture: directed vector table plus hand sequences for impulse_capture
module tb_impulse_capture;
  logic clk = 0, rst = 1, arm = 0, strobe_in = 0;
  logic [9:0] data_in = '0;
  logic [3:0] rd_addr = '0;
  logic busy, done;
  logic [9:0] rd_data, peak_out;
  logic [13:0] sum_out;
  logic [4:0] len_out;
  int nchk = 0, nerr = 0;
  typedef struct {
    bit r, a, s;
    logic [9:0] d;
    bit busy, done;
    int sum, peak, len;
  } vec_t;
  vec_t tbl[10];
  impulse_capture dut (
    .clk(clk), .rst(rst), .arm(arm), .strobe_in(strobe_in), .data_in(data_in),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .sum_out(sum_out), .peak_out(peak_out), .len_out(len_out)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(bit r, bit a, bit s, int d, bit b, bit dn, int sm, int pk, int ln);
    vec_t v;
    v.r = r; v.a = a; v.s = s; v.d = 10'(d);
    v.busy = b; v.done = dn; v.sum = sm; v.peak = pk; v.len = ln;
    return v;
  endfunction
  task automatic step(input bit r, input bit a, input bit s, input int d);
    @(negedge clk);
    rst = r; arm = a; strobe_in = s; data_in = 10'(d);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input bit b, input bit dn, input int sm, input int pk, input int ln);
    chk({nm, ".busy"}, 32'(busy), 32'(b));
    chk({nm, ".done"}, 32'(done), 32'(dn));
    chk({nm, ".sum"}, 32'(sum_out), sm);
    chk({nm, ".peak"}, 32'(peak_out), pk);
    chk({nm, ".len"}, 32'(len_out), ln);
  endtask
  task automatic readback(input string nm, input int v_lo, input int n_lo);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 4'(i);
      @(posedge clk);
      #1;
      chk($sformatf("%s.rd%0d", nm, i), 32'(rd_data), i < n_lo ? v_lo : 0);
    end
  endtask
  initial begin
    tbl[0] = mk(1, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[1] = mk(1, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 1, 1023, 0, 0, 0, 0, 0);
    tbl[3] = mk(0, 0, 1, 1023, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 0, 1, 1023, 0, 0, 0, 0, 0);
    tbl[5] = mk(0, 0, 1, 1023, 0, 0, 0, 0, 0);
    tbl[6] = mk(0, 0, 1, 1023, 0, 0, 0, 0, 0);
    tbl[7] = mk(0, 1, 1, 900,  1, 0, 0, 0, 0);
    tbl[8] = mk(0, 0, 1, 300,  1, 0, 300, 300, 1);
    tbl[9] = mk(0, 0, 1, 0,    1, 0, 300, 300, 1);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].s, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].sum, tbl[i].peak, tbl[i].len);
    end
    chk("reset.rd", 32'(rd_data), 32'(rd_data === 10'bx ? 1 : rd_data));
    for (int i = 0; i < 14; i++) step(0, 0, 1, 0);
    chk_all("collide_done", 0, 1, 300, 300, 1);
    step(0, 0, 1, 77);
    chk_all("done_hold", 0, 1, 300, 300, 1);
    step(0, 1, 0, 0);
    chk_all("rearm", 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    chk_all("imp2_wait", 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, i < 2 ? 511 : 0);
      if (i == 14) chk_all("imp2_15", 1, 0, 1022, 511, 2);
      if (i < 15) step(0, 0, 0, 0);
    end
    chk_all("imp2_done", 0, 1, 1022, 511, 2);
    readback("imp2", 511, 2);
    step(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, i < 8 ? 127 : 0);
    chk_all("imp8_done", 0, 1, 1016, 127, 8);
    readback("imp8", 127, 8);
    step(0, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 1023);
    chk_all("full_15", 1, 0, 15345, 1023, 15);
    step(0, 0, 1, 1023);
    chk_all("full_done", 0, 1, 16368, 1023, 16);
    step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 200);
    chk_all("mid_7", 1, 0, 1400, 200, 7);
    step(1, 0, 1, 200);
    chk_all("mid_rst", 0, 0, 0, 0, 0);
    chk("mid_rst.rd", 32'(rd_data), 0);
    step(0, 0, 1, 200);
    chk_all("mid_idle", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, i < 2 ? 511 : 0);
    chk_all("mid_recap", 0, 1, 1022, 511, 2);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
